// File: rtl/axi_lite_master_cmd.sv
// axi_lite_master_cmd
//   AXI4-Lite initiator that turns a single-beat command/response stream into
//   AXI4-Lite read and write transactions, one outstanding at a time.
//
// Ports
//   aclk, areset           : clock, synchronous active-high reset
//   cmd_valid/cmd_ready    : command handshake
//   cmd_write/addr/wdata   : command payload (1 = write, 0 = read)
//   rsp_valid/rsp_ready    : response handshake
//   rsp_write/rdata/resp   : response payload (rdata is 0 for writes)
//   m_axi_lite_*           : AXI4-Lite master AW, W, B, AR and R channels
//   err_timeout            : sticky no-response flag
//
// Optional feature
//   AXI_LITE_MASTER_TIMEOUT_EN
//     When defined, a cycle counter sets err_timeout after P_TIMEOUT cycles
//     without the transaction completing. When undefined, err_timeout is 0.
//
// Every output is a flop, so there is no combinational input-to-output path.
module axi_lite_master_cmd #(
  parameter int P_ADDR_WIDTH = 32,
  parameter int P_DATA_WIDTH = 32,
  parameter int P_TIMEOUT    = 1024
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [P_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [P_DATA_WIDTH-1:0] cmd_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [P_DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic [P_ADDR_WIDTH-1:0] m_axi_lite_awaddr,
  output logic                    m_axi_lite_awvalid,
  input  logic                    m_axi_lite_awready,
  output logic [P_DATA_WIDTH-1:0] m_axi_lite_wdata,
  output logic                    m_axi_lite_wvalid,
  input  logic                    m_axi_lite_wready,
  input  logic [1:0]              m_axi_lite_bresp,
  input  logic                    m_axi_lite_bvalid,
  output logic                    m_axi_lite_bready,
  output logic [P_ADDR_WIDTH-1:0] m_axi_lite_araddr,
  output logic                    m_axi_lite_arvalid,
  input  logic                    m_axi_lite_arready,
  input  logic [P_DATA_WIDTH-1:0] m_axi_lite_rdata,
  input  logic [1:0]              m_axi_lite_rresp,
  input  logic                    m_axi_lite_rvalid,
  output logic                    m_axi_lite_rready,
  output logic                    err_timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_AW_W,
    S_WR_B,
    S_RD_AR,
    S_RD_R,
    S_RSP
  } state_t;

  state_t                  state_q,     state_d;
  logic                    cmd_ready_q, cmd_ready_d;
  logic [P_ADDR_WIDTH-1:0] awaddr_q,    awaddr_d;
  logic                    awvalid_q,   awvalid_d;
  logic [P_DATA_WIDTH-1:0] wdata_q,     wdata_d;
  logic                    wvalid_q,    wvalid_d;
  logic                    bready_q,    bready_d;
  logic [P_ADDR_WIDTH-1:0] araddr_q,    araddr_d;
  logic                    arvalid_q,   arvalid_d;
  logic                    rready_q,    rready_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    rsp_write_q, rsp_write_d;
  logic [P_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]              rsp_resp_q,  rsp_resp_d;

  logic cmd_accept;
  logic aw_done;
  logic w_done;

  // cmd_ready_q is only ever high in IDLE, so this is the accept strobe.
  assign cmd_accept = cmd_valid & cmd_ready_q;
  assign aw_done    = awvalid_q & m_axi_lite_awready;
  assign w_done     = wvalid_q & m_axi_lite_wready;

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    awaddr_d    = awaddr_q;
    awvalid_d   = awvalid_q;
    wdata_d     = wdata_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    araddr_d    = araddr_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;

    case (state_q)
      S_IDLE: begin
        // The first IDLE cycle after reset has cmd_ready low; raise it here.
        cmd_ready_d = 1'b1;
        if (cmd_accept) begin
          cmd_ready_d = 1'b0;
          if (cmd_write) begin
            awaddr_d  = cmd_addr;
            wdata_d   = cmd_wdata;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_WR_AW_W;
          end else begin
            araddr_d  = cmd_addr;
            arvalid_d = 1'b1;
            state_d   = S_RD_AR;
          end
        end
      end

      S_WR_AW_W: begin
        // AW and W complete independently; leave once neither is pending,
        // which also covers both finishing on the same edge.
        if (aw_done) awvalid_d = 1'b0;
        if (w_done)  wvalid_d  = 1'b0;
        if ((aw_done || !awvalid_q) && (w_done || !wvalid_q)) begin
          bready_d = 1'b1;
          state_d  = S_WR_B;
        end
      end

      S_WR_B: begin
        if (m_axi_lite_bvalid) begin
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = m_axi_lite_bresp;
          state_d     = S_RSP;
        end
      end

      S_RD_AR: begin
        if (m_axi_lite_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD_R;
        end
      end

      S_RD_R: begin
        if (m_axi_lite_rvalid) begin
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b0;
          rsp_rdata_d = m_axi_lite_rdata;
          rsp_resp_d  = m_axi_lite_rresp;
          state_d     = S_RSP;
        end
      end

      S_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d     = S_IDLE;
        cmd_ready_d = 1'b0;
        awvalid_d   = 1'b0;
        wvalid_d    = 1'b0;
        bready_d    = 1'b0;
        arvalid_d   = 1'b0;
        rready_d    = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b0;
      awaddr_q    <= '0;
      awvalid_q   <= 1'b0;
      wdata_q     <= '0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      araddr_q    <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      awaddr_q    <= awaddr_d;
      awvalid_q   <= awvalid_d;
      wdata_q     <= wdata_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      araddr_q    <= araddr_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(P_TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_timeout_q, err_timeout_d;
  logic             busy;

  assign busy = (state_q == S_WR_AW_W) || (state_q == S_WR_B) ||
                (state_q == S_RD_AR)   || (state_q == S_RD_R);

  // The count is cleared by the accept edge, so the first cycle of the
  // transaction sees 0 and the flag rises on the edge that takes the count
  // to P_TIMEOUT. The counter saturates; the FSM keeps waiting regardless.
  always_comb begin
    cnt_d         = cnt_q;
    err_timeout_d = err_timeout_q;
    if (cmd_accept) begin
      cnt_d         = '0;
      err_timeout_d = 1'b0;
    end else if (busy && (cnt_q != CNT_W'(P_TIMEOUT))) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(P_TIMEOUT - 1)) err_timeout_d = 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      cnt_q         <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign err_timeout = err_timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^P_TIMEOUT;
  assign err_timeout        = 1'b0;
`endif

  assign cmd_ready          = cmd_ready_q;
  assign m_axi_lite_awaddr  = awaddr_q;
  assign m_axi_lite_awvalid = awvalid_q;
  assign m_axi_lite_wdata   = wdata_q;
  assign m_axi_lite_wvalid  = wvalid_q;
  assign m_axi_lite_bready  = bready_q;
  assign m_axi_lite_araddr  = araddr_q;
  assign m_axi_lite_arvalid = arvalid_q;
  assign m_axi_lite_rready  = rready_q;
  assign rsp_valid          = rsp_valid_q;
  assign rsp_write          = rsp_write_q;
  assign rsp_rdata          = rsp_rdata_q;
  assign rsp_resp           = rsp_resp_q;

endmodule

// File: doc/axi_lite_master_cmd.md
# axi_lite_master_cmd

Synthesizable AXI4-Lite initiator that converts a simple single-beat command/response stream into AXI4-Lite read and write transactions. It is the hardware counterpart of the responder-side peripherals (GPIO and others) on the AXI4-Lite register bus. It lets an on-chip controller or sequencer reach those peripherals without the co-simulation BFM. One transaction is outstanding at a time.

## Interface
- Parameters:
- P_ADDR_WIDTH, 32, AXI and command address width
- P_DATA_WIDTH, 32, AXI and command data width
- P_TIMEOUT, 1024, cycles without a response before the timeout flag sets (only with the macro)
- Ports:
- Clocking and reset: one clock; reset is synchronous and active-high.
- aclk  in  1  bus clock; all logic on the rising edge
- areset  in  1  synchronous active-high reset
- cmd_valid / cmd_ready  in / out  1  command handshake
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  P_ADDR_WIDTH  byte address, passed unmodified
- cmd_wdata  in  P_DATA_WIDTH  write data
- rsp_valid / rsp_ready  out / in  1  response handshake
- rsp_write  out  1  echo of cmd_write
- rsp_rdata  out  P_DATA_WIDTH  read data; 0 for writes
- rsp_resp  out  2  BRESP or RRESP
- m_axi_lite_aw*, w*, b*, ar*, r*  AXI4-Lite master channels: awaddr, awvalid, awready, wdata, wvalid, wready, bresp, bvalid, bready, araddr, arvalid, arready, rdata, rresp, rvalid, rready
- err_timeout  out  1  sticky timeout flag

## Operation
- FSM states: IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP.
- IDLE:
  - cmd_ready = 1, only in this state.
  - On cmd_valid, the command is latched.
  - Write commands go to WR_AW_W; reads go to RD_AR.
- WR_AW_W:
  - awvalid and wvalid both rise together and are tracked independently.
  - Each valid drops the cycle after its own handshake.
  - The state exits to WR_B when both handshakes are done, including the case where both complete in the same cycle.
- WR_B: bready = 1. On bvalid, latch bresp and go to RSP.
- RD_AR: arvalid = 1. On arready, go to RD_R.
- RD_R: rready = 1. On rvalid, latch rdata and rresp and go to RSP.
- RSP: rsp_valid = 1 with stable payload. On rsp_ready, go to IDLE.
- Address, data and valid outputs are stable while valid is high and the channel is unacknowledged. Valids are never withdrawn before handshake.
- Error responses (SLVERR/DECERR) are forwarded unchanged; no retry.
- Reset mid-transaction:
  - All outputs return to reset values on the next edge and the FSM returns to IDLE.
  - The outstanding transaction is abandoned.

## Timing
- Reset values:
  - cmd_ready = 1 once reset deasserts; 0 while areset is high.
  - All AXI valid and ready outputs = 0; rsp_valid = 0; rsp_* = 0; err_timeout = 0.
  - Address and data outputs = 0.
- All outputs are registered. There is no combinational path from any input to any output.
- Write against a zero-wait responder:
  - Cycle 0: command accepted.
  - Cycle 1: AW and W handshake.
  - Cycle 2: bready=1 and B handshake.
  - Cycle 3: rsp_valid=1.
- Read against a zero-wait responder:
  - Cycle 0: command accepted.
  - Cycle 1: AR handshake.
  - Cycle 2: R handshake.
  - Cycle 3: rsp_valid=1.
- Back-to-back: the next command is accepted in the cycle after the rsp handshake, giving a minimum 4-cycle period.

## Configuration
- Macro AXI_LITE_MASTER_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WR_AW_W or RD_AR and increments each cycle in any non-IDLE, non-RSP state.
  - When the count reaches P_TIMEOUT, err_timeout sets. The FSM keeps waiting, so protocol is preserved.
  - err_timeout clears on reset or on the next accepted command.
- Undefined: the counter is absent and err_timeout is tied to 0.

## Test plan
- Write 0x0000_0004 <= 0xA5A5_5A5A, zero-wait responder -> AW and W in cycle 1; rsp_valid in cycle 3 with rsp_write=1, rsp_resp=0, rsp_rdata=0.
- Read 0x0000_0000, responder returns 0x1234_5678 / OKAY -> rsp_rdata=0x1234_5678 in cycle 3.
- awready delayed 3 cycles, wready immediate -> wvalid drops after cycle 1; awvalid held with awaddr stable until cycle 4; exactly one B accepted.
- Responder bresp=2'b10; rsp_ready held low 5 cycles -> rsp_resp=2'b10; rsp_valid and payload stable for 5 cycles; cmd_ready=0 throughout.
- With macro, P_TIMEOUT=16, arready held low -> err_timeout=1 at cycle 17 after entering RD_AR while arvalid stays high; the late arready completes normally. Without macro -> err_timeout stays 0.
- areset pulsed in WR_B -> next edge: bready=0, rsp_valid=0, cmd_ready=0 during reset, then 1 the cycle after reset deasserts.
